// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the memory-side burst responder.
// A line is four bytes; offsets inside a line are two bits wide and wrap.
package mem_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        WR_BEAT,
        DONE
    } state_t;

    localparam int BURST_LEN = 4;
    localparam int OFFS_W    = 2;

    // Clears the within-line offset bits so the result is the first byte of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~32'(BURST_LEN - 1);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port byte store with synchronous read and synchronous write.
// Contents are deliberately not reset so data survives a responder reset.
module mem_array #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    // Write when enabled and always register the addressed byte for the next cycle.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache line fills and write-backs.
// Each accepted request moves one four-byte line; ready_mem pulses when done.
// Optional build macro CRIT_WORD_FIRST_EN: read bursts start at the requested
// word offset and wrap around the line; without it reads always start at offset 0.
module mem_burst_responder
    import mem_burst_pkg::*;
#(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int LAT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              wdata_valid,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              data_last,
    output logic [1:0]        beat_idx,
    output logic              ready_mem,
    output logic              busy
);

    localparam logic [3:0] LAT_LOAD = 4'(LAT_CYCLES);

    state_t              state;
    logic [AWIDTH-1:0]   base_addr;
    logic [OFFS_W-1:0]   start_off;
    logic [OFFS_W-1:0]   beat_cnt;
    logic [3:0]          lat_cnt;
    logic                line_done;
    logic [OFFS_W-1:0]   rd_start;
    logic                lead;
    logic [OFFS_W-1:0]   mem_off;
    logic [AWIDTH-1:0]   mem_addr;
    logic                mem_we;
    logic [DWIDTH-1:0]   mem_rdata;

`ifdef CRIT_WORD_FIRST_EN
    assign rd_start = addr_mem[OFFS_W-1:0];
`else
    assign rd_start = '0;
`endif

    // Store address: reads run one word ahead of the beat being presented so the
    // synchronous read data is ready when the output register samples it.
    always_comb begin
        lead     = (state == RD_BEAT) || ((state == RD_WAIT) && (lat_cnt == 4'd0));
        mem_off  = start_off + beat_cnt + OFFS_W'(lead);
        mem_addr = base_addr | AWIDTH'(mem_off);
        mem_we   = (state == WR_BEAT) && wdata_valid && !line_done;
    end

    mem_array #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH)
    ) u_mem (
        .clock(clock),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(data_in),
        .rdata(mem_rdata)
    );

    // Burst sequencing FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_addr  <= '0;
            start_off  <= '0;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
            line_done  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            beat_idx   <= '0;
            ready_mem  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_mem) begin
                        state     <= WR_BEAT;
                        base_addr <= AWIDTH'(line_base(32'(addr_mem)));
                        start_off <= '0;
                        beat_cnt  <= '0;
                        line_done <= 1'b0;
                        busy      <= 1'b1;
                    end else if (rd_mem) begin
                        state     <= RD_WAIT;
                        base_addr <= AWIDTH'(line_base(32'(addr_mem)));
                        start_off <= rd_start;
                        beat_cnt  <= '0;
                        lat_cnt   <= LAT_LOAD;
                        line_done <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state      <= RD_BEAT;
                        data_out   <= mem_rdata;
                        data_valid <= 1'b1;
                        data_last  <= 1'b0;
                        beat_idx   <= start_off + beat_cnt;
                        beat_cnt   <= beat_cnt + 2'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RD_BEAT: begin
                    if (line_done) begin
                        state      <= DONE;
                        data_out   <= '0;
                        data_valid <= 1'b0;
                        data_last  <= 1'b0;
                        beat_idx   <= '0;
                        ready_mem  <= 1'b1;
                    end else begin
                        data_out  <= mem_rdata;
                        data_last <= (beat_cnt == 2'd3);
                        beat_idx  <= start_off + beat_cnt;
                        beat_cnt  <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            line_done <= 1'b1;
                        end
                    end
                end
                WR_BEAT: begin
                    if (line_done) begin
                        state     <= DONE;
                        ready_mem <= 1'b1;
                    end else if (wdata_valid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            line_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ready_mem <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Self-checking bench for mem_burst_responder: directed scenarios followed by
// random line reads/writes checked against a byte-array model of the store.
module tb_mem_burst_responder;

    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int LAT = 2;

`ifdef CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          rd_mem;
    logic          wr_mem;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] data_in;
    logic          wdata_valid;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_last;
    logic [1:0]    beat_idx;
    logic          ready_mem;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] model   [512];
    logic       written [512];

    mem_burst_responder #(
        .AWIDTH    (AW),
        .DWIDTH    (DW),
        .LAT_CYCLES(LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_mem     (rd_mem),
        .wr_mem     (wr_mem),
        .addr_mem   (addr_mem),
        .data_in    (data_in),
        .wdata_valid(wdata_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_last  (data_last),
        .beat_idx   (beat_idx),
        .ready_mem  (ready_mem),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Single comparison point: counts the check and reports any difference.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_data_out"},   32'(data_out),   32'd0);
        check_output({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check_output({tag, "_data_last"},  32'(data_last),  32'd0);
        check_output({tag, "_beat_idx"},   32'(beat_idx),   32'd0);
        check_output({tag, "_ready_mem"},  32'(ready_mem),  32'd0);
        check_output({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    // Write burst: beats follow acceptance, with an optional stall of gap_len cycles
    // placed before beat gap_at; ready_mem is due one cycle after the last beat.
    task automatic write_burst(input logic [AW-1:0] addr, input logic [31:0] line,
                               input int gap_at, input int gap_len, input logic rd_too);
        int base;
        int rdy;
        int beat;
        base = int'(addr) & ~3;
        rdy  = 5 + gap_len;
        @(negedge clock);
        wr_mem   = 1'b1;
        rd_mem   = rd_too;
        addr_mem = addr;
        @(negedge clock);
        wr_mem = 1'b0;
        rd_mem = 1'b0;
        check_output("wr_busy_rise", 32'(busy), 32'd1);
        for (int k = 1; k <= rdy + 1; k++) begin
            if (k <= gap_at) beat = k - 1;
            else if (k <= gap_at + gap_len) beat = -1;
            else beat = k - 1 - gap_len;
            if (beat >= 0 && beat < 4) begin
                wdata_valid = 1'b1;
                data_in     = line[8*beat +: 8];
                model[base + beat]   = data_in;
                written[base + beat] = 1'b1;
            end else begin
                wdata_valid = 1'b0;
                data_in     = 8'($urandom);
            end
            rd_mem   = rd_too && (k == 2);
            addr_mem = 9'($urandom);
            @(negedge clock);
            check_output("wr_ready", 32'(ready_mem), 32'(k == rdy));
            check_output("wr_busy", 32'(busy), 32'(k <= rdy));
            check_output("wr_no_beats", 32'(data_valid), 32'd0);
        end
        wdata_valid = 1'b0;
        rd_mem      = 1'b0;
    endtask

    // Read burst: beats start LAT+1 cycles after acceptance; optionally assert
    // reset right after cycle abort_k and check that every output clears.
    task automatic read_burst(input logic [AW-1:0] addr, input int abort_k);
        int s;
        int base;
        int rdy;
        int beat;
        int off;
        s    = CWF ? int'(addr[1:0]) : 0;
        base = int'(addr) & ~3;
        rdy  = LAT + 5;
        @(negedge clock);
        rd_mem   = 1'b1;
        addr_mem = addr;
        for (int k = 0; k <= rdy + 1; k++) begin
            @(negedge clock);
            rd_mem   = 1'b0;
            addr_mem = 9'($urandom);
            if (k == 0) continue;
            beat = k - (LAT + 1);
            check_output("rd_valid", 32'(data_valid), 32'(beat >= 0 && beat < 4));
            check_output("rd_ready", 32'(ready_mem), 32'(k == rdy));
            check_output("rd_busy", 32'(busy), 32'(k <= rdy));
            if (beat >= 0 && beat < 4) begin
                off = (s + beat) % 4;
                check_output("rd_beat_idx", 32'(beat_idx), 32'(off));
                check_output("rd_last", 32'(data_last), 32'(beat == 3));
                if (written[base + off]) begin
                    check_output("rd_data", 32'(data_out), 32'(model[base + off]));
                end
            end
            if (k == abort_k) begin
                reset = 1'b1;
                #1;
                check_all_zero("rst_mid_read");
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rd_mem = 1'b0;
            wr_mem = 1'b0;
            @(negedge clock);
            check_output("idle_valid", 32'(data_valid), 32'd0);
            check_output("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Directed scenarios then randomized traffic, all in one linear sequence.
    initial begin
        logic [AW-1:0] ra;
        reset       = 1'b1;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        addr_mem    = '0;
        data_in     = '0;
        wdata_valid = 1'b0;
        for (int i = 0; i < 512; i++) begin
            written[i] = 1'b0;
            model[i]   = 8'h00;
        end
        @(negedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] write line 0x010 then read from 0x012");
        write_burst(9'h010, 32'hA3A2A1A0, 0, 0, 1'b0);
        read_burst(9'h012, -1);

        $display("[TB] write 0x020 with a three-cycle stall before beat 2");
        write_burst(9'h020, 32'h5C3B2A19, 2, 3, 1'b0);
        read_burst(9'h020, -1);

        $display("[TB] simultaneous read and write requests");
        write_burst(9'h031, 32'hDEADBEEF, 0, 0, 1'b1);
        idle_cycles(6);
        read_burst(9'h030, -1);

        $display("[TB] reset during the second read beat");
        read_burst(9'h010, LAT + 2);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("after_reset");
        read_burst(9'h010, -1);

        $display("[TB] top line must not wrap into address 0");
        write_burst(9'h000, 32'h88776655, 0, 0, 1'b0);
        write_burst(9'h1FD, 32'h44332211, 1, 2, 1'b0);
        read_burst(9'h1FE, -1);
        read_burst(9'h000, -1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 24; n++) begin
            ra = 9'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                write_burst(ra, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
            end else begin
                read_burst(ra, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the cache line-fill/write-back protocol: accepts one-beat read or write burst requests from the cache controller and transfers a full 4-byte line on consecutive beats. It owns the byte-addressed backing store and replaces ad-hoc address sequencing in the integration wrapper. It sits between the cache's memory port and the physical store, and signals line completion with `ready_mem`.

## Interface
- `AWIDTH`, 9: byte address width; store holds 2**AWIDTH bytes.
- `DWIDTH`, 8: data beat width.
- `LAT_CYCLES`, 2: wait cycles between read acceptance and first read beat; legal range 1..15.
- `clock`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rd_mem`  in  1: read-burst request, sampled only in IDLE.
- `wr_mem`  in  1: write-burst request, sampled only in IDLE.
- `addr_mem`  in  AWIDTH: request address; line base = {addr_mem[AWIDTH-1:2],2'b00}.
- `data_in`  in  DWIDTH: write beat data.
- `wdata_valid`  in  1: `data_in` valid this cycle (write bursts only).
- `data_out`  out  DWIDTH: read beat data.
- `data_valid`  out  1: `data_out` valid.
- `data_last`  out  1: marks the 4th read beat.
- `beat_idx`  out  2: word offset of the current read beat.
- `ready_mem`  out  1: one-cycle pulse, line transfer complete.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, RD_WAIT, RD_BEAT, WR_BEAT, DONE.
- IDLE: `wr_mem` has priority over `rd_mem` (write-back before fill); a write is accepted and goes to WR_BEAT; a read goes to RD_WAIT. Address latched at acceptance.
- RD_WAIT: latency counter loads LAT_CYCLES at acceptance and decrements; goes to RD_BEAT when it expires.
- RD_BEAT: exactly 4 consecutive beats, no backpressure; `data_valid`=1 each beat; `data_last`=1 on beat 4; then DONE.
- WR_BEAT: each cycle with `wdata_valid`=1 stores `data_in` at line base + beat counter and increments the counter; `wdata_valid`=0 holds the counter. After the 4th accepted beat, goes to DONE.
- DONE: `ready_mem`=1 for one cycle; returns to IDLE.
- Requests in any state other than IDLE are ignored, not queued.
- Beat counter is 2 bits and wraps modulo 4; addresses never carry outside the line (line 0x1FC..0x1FF never touches 0x000).
- Reset: all outputs 0 immediately, state IDLE, counters 0. Store contents are not reset and persist across reset.

## Timing
- Read: request at edge T; beats at edges T+LAT_CYCLES+1 .. T+LAT_CYCLES+4; `ready_mem` at T+LAT_CYCLES+5; IDLE at the following edge.
- Write with continuous `wdata_valid`: beats stored at T+1..T+4; `ready_mem` at T+5.
- `data_out` is registered. The store has synchronous read, so the read address is issued one cycle ahead of each beat.
- `busy` rises the cycle after acceptance and falls when the state leaves DONE.

## Configuration
- `CRIT_WORD_FIRST_EN` defined: read bursts start at addr_mem[1:0] and wrap, e.g. offset 2 gives 2,3,0,1; `beat_idx` reports the actual offset.
- Not defined: read bursts always start at offset 0, and addr_mem[1:0] is ignored.
- Write bursts always start at offset 0 in both builds.

## Structure
- Package `mem_burst_pkg`: state enum, BURST_LEN=4, OFFS_W=2, and a line-base helper function.
- Sub-module `mem_array`: single-port byte RAM with synchronous read and synchronous write, of depth 2**AWIDTH.
- Responder contains only the FSM, counters and output registers.

## Test plan
- Reset, then write burst to `addr_mem`=0x010 with data A0,A1,A2,A3 and continuous `wdata_valid` -> bytes stored at 0x010..0x013; `ready_mem` pulses at T+5; `busy` drops the next cycle.
- Read from 0x012 with LAT_CYCLES=2 -> beats start at T+3: A0,A1,A2,A3 with `data_last` on A3. With CRIT_WORD_FIRST_EN -> A2,A3,A0,A1 with `beat_idx` 2,3,0,1.
- Write 0x020 with `wdata_valid` low for 3 cycles before beat 2 -> counter holds; all 4 bytes correct; `ready_mem` at T+8.
- `rd_mem`=`wr_mem`=1 in IDLE -> only the write executes; a `rd_mem` pulse during the write is ignored, and no read beats follow.
- Assert `reset` during read beat 2 -> all outputs 0 in the same cycle and `busy`=0; a later read of 0x010 still returns A0..A3.
- Write then read line 0x1FC..0x1FF with data 11,22,33,44 -> read returns 11,22,33,44; byte 0x000 is unchanged.
